fir_stereo_sequencer: RTL and testbench
=======================================

# fir_stereo_sequencer

Sequences one stereo sample through the audio path: takes a left/right pair from the audio CODEC read port, launches one FIR instance per channel, waits for both results in either order, then hands the filtered pair to the CODEC write port in a single write. It sits between `audio_codec` and two `fir` instances at the top level, replacing the direct ready/valid wiring. It adds per-channel bypass, a completion timeout and an error counter.

## Interface
Parameters:
- `DW`, default 16: FIR sample width; FIR operates on bits [23:24-DW] of each CODEC word.
- `TIMEOUT`, default 1023: cycles allowed in RUN before missing results are forced.

Ports:
- `ck` in 1: system clock (CLOCK_50 domain).
- `rst` in 1: synchronous, active-high reset.
- `read_ready` in 1: CODEC has a sample pair available.
- `readdata_left`, `readdata_right` in 24 each: CODEC sample pair.
- `read` out 1: one-cycle pop of the CODEC read FIFO.
- `write_ready` in 1: CODEC can accept a pair.
- `write` out 1: one-cycle push to the CODEC write FIFO.
- `writedata_left`, `writedata_right` out 24 each: pair to the CODEC.
- `fir_l_in`, `fir_r_in` out DW each: FIR input samples.
- `fir_l_start`, `fir_r_start` out 1 each: one-cycle FIR `input_ready` pulses.
- `fir_l_out`, `fir_r_out` in DW each: FIR results.
- `fir_l_done`, `fir_r_done` in 1 each: FIR `output_ready` pulses.
- `bypass_l`, `bypass_r` in 1 each: route the channel around its FIR.
- `busy` out 1: high whenever the state is not IDLE.
- `timeout_count` out 8: saturating count of forced channel results.

## Operation
- FSM states: IDLE, START, RUN, WAIT_WR. Reset forces IDLE.
- **IDLE**
  - `read = read_ready & ~rst`, combinational.
  - On a read cycle, register `readdata_left[23:24-DW]` into `samp_l` and `readdata_right[23:24-DW]` into `samp_r`, then go to START.
- **START**
  - Sample `bypass_l` and `bypass_r`.
  - For each non-bypassed channel: pulse `fir_x_start` for this cycle only, drive `fir_x_in = samp_x`, clear `done_x`.
  - For each bypassed channel: set `res_x = samp_x` and set `done_x`.
  - Clear the timeout counter. Go to RUN.
  - `fir_x_in` holds `samp_x` from START until the next START.
- **RUN**
  - A `fir_x_done` pulse with `done_x = 0` captures `fir_x_out` into `res_x` and sets `done_x`.
  - Done pulses when `done_x = 1` are ignored.
  - `fir_l_done` and `fir_r_done` in the same cycle capture both channels.
  - When `done_l & done_r`, go to WAIT_WR on the next cycle.
  - The timeout counter increments every RUN cycle. When it reaches TIMEOUT:
    - each channel with `done_x = 0` gets `res_x = 0` and `done_x = 1`;
    - `timeout_count` increments by 1 per forced channel (max 2 per sample), saturating at 255;
    - go to WAIT_WR.
- **WAIT_WR**
  - `write = write_ready`, combinational.
  - `writedata_x = {res_x, (24-DW)'b0}`, held stable throughout WAIT_WR.
  - On a write cycle, go to IDLE.
- Done pulses seen in IDLE, START or WAIT_WR are ignored.
- `read_ready` is ignored outside IDLE; the CODEC FIFO buffers.
- `rst` mid-operation:
  - return to IDLE next cycle;
  - clear `done_*`, `res_*`, `samp_*` and `timeout_count`;
  - an in-flight FIR result arriving after reset is discarded.

## Timing
- Reset values:
  - `read`, `write`, `fir_*_start`, `busy` = 0;
  - `writedata_*`, `fir_*_in` = 0;
  - `timeout_count` = 0.
- Read accepted at cycle T: START at T+1 (start pulses), RUN from T+2.
- Last done pulse at cycle D (D ≥ T+2): WAIT_WR at D+1. Earliest write is at D+1 if `write_ready` is high.
- Both channels bypassed: RUN at T+2, WAIT_WR at T+3, earliest write at T+3.
- Timeout: RUN is entered at T+2. The force happens in the cycle where the counter equals TIMEOUT, and WAIT_WR follows on the next cycle.
- Minimum spacing between consecutive `read` pulses is 4 cycles (IDLE, START, RUN, WAIT_WR each occupy at least one cycle).
- `read` and `write` are never high in the same cycle.

## Test plan
- Normal path, DW=16:
  - Stimulus: `readdata_left` = 24'h123456, `readdata_right` = 24'hABCDEF, `read_ready` high; FIR models return `in+1` after 5 cycles; `write_ready` high.
  - Required: one `read` pulse; `fir_l_in` = 16'h1234 and `fir_r_in` = 16'hABCD, each with a one-cycle start pulse at T+1; one `write` with left = 24'h123500 and right = 24'hABCE00.
- Out-of-order and simultaneous completion:
  - Stimulus: right done at T+3, left done at T+9; then a second sample with both done in the same cycle.
  - Required: a single `write` per sample, issued one cycle after the last done, with correct values.
- Bypass:
  - Stimulus: `bypass_l` = 1, `bypass_r` = 0, left input 24'h7FFF00.
  - Required: no `fir_l_start`; `writedata_left` = 24'h7FFF00.
  - Stimulus: both bypassed.
  - Required: `write` at T+3.
- Timeout:
  - Stimulus: TIMEOUT = 8, right FIR never responds.
  - Required: write with right = 0 and left = the filtered value; `timeout_count` = 1.
  - Stimulus: repeat 300 times with both FIRs silent.
  - Required: `timeout_count` saturates at 255.
- Backpressure and reset:
  - Stimulus: `write_ready` low for 50 cycles after results are ready.
  - Required: `writedata` stable, `busy` high, no `read`; write issued on the first `write_ready` cycle.
  - Stimulus: assert `rst` in RUN, then deliver a stale done pulse.
  - Required: IDLE, all outputs 0, stale result discarded; the next sample processes normally.

Source files
------------

// File: rtl/fir_stereo_sequencer.sv
// Stereo FIR sequencer: pops one CODEC pair, runs a FIR per channel (or bypasses it),
// gathers both results in any order with a timeout, then pushes the filtered pair.
module fir_seq_lane #(
  parameter int DW = 16
) (
  input  logic          ck,
  input  logic          rst,
  input  logic          load,
  input  logic          start,
  input  logic          run,
  input  logic          tmo,
  input  logic          bypass,
  input  logic          fir_done,
  input  logic [DW-1:0] din,
  input  logic [DW-1:0] fir_out,
  output logic [DW-1:0] res,
  output logic [DW-1:0] fir_in,
  output logic          fir_start,
  output logic          done,
  output logic          done_nxt,
  output logic          forced
);
  logic [DW-1:0] samp, in_q;
  logic          capture;

  assign capture   = run & fir_done & ~done;
  // a real result landing in the timeout cycle wins over the forced zero
  assign forced    = tmo & ~done & ~capture;
  assign done_nxt  = done | capture;
  assign fir_start = start & ~bypass & ~rst;
  assign fir_in    = rst ? '0 : (fir_start ? samp : in_q);

  always_ff @(posedge ck) begin
    if (rst) begin
      samp <= '0;
      in_q <= '0;
      res  <= '0;
      done <= 1'b0;
    end else begin
      if (load) samp <= din;
      if (start) begin
        if (bypass) begin
          res  <= samp;
          done <= 1'b1;
        end else begin
          done <= 1'b0;
          in_q <= samp;
        end
      end else if (capture) begin
        res  <= fir_out;
        done <= 1'b1;
      end else if (forced) begin
        res  <= '0;
        done <= 1'b1;
      end
    end
  end
endmodule

module fir_stereo_sequencer #(
  parameter int DW      = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic          ck,
  input  logic          rst,
  input  logic          read_ready,
  input  logic [23:0]   readdata_left,
  input  logic [23:0]   readdata_right,
  output logic          read,
  input  logic          write_ready,
  output logic          write,
  output logic [23:0]   writedata_left,
  output logic [23:0]   writedata_right,
  output logic [DW-1:0] fir_l_in,
  output logic [DW-1:0] fir_r_in,
  output logic          fir_l_start,
  output logic          fir_r_start,
  input  logic [DW-1:0] fir_l_out,
  input  logic [DW-1:0] fir_r_out,
  input  logic          fir_l_done,
  input  logic          fir_r_done,
  input  logic          bypass_l,
  input  logic          bypass_r,
  output logic          busy,
  output logic [7:0]    timeout_count
);
  localparam int NL = 2;
  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, START, RUN, WAIT_WR} state_t;
  state_t state, nxt;

  logic [CW-1:0]              tcnt;
  logic                       tmo;
  logic [NL-1:0][DW-1:0]      din, fout, res, fin;
  logic [NL-1:0]              byp, fdone, fstart, done, done_nxt, forced;
  logic [8:0]                 tsum;
  logic                       unused_low;

  // lane 0 is left, lane 1 is right
  assign din   = {readdata_right[23 -: DW], readdata_left[23 -: DW]};
  assign fout  = {fir_r_out, fir_l_out};
  assign byp   = {bypass_r, bypass_l};
  assign fdone = {fir_r_done, fir_l_done};
  assign unused_low = ^{readdata_left[23-DW:0], readdata_right[23-DW:0], done};

  assign tmo = (state == RUN) && (tcnt == CW'(TIMEOUT));

  for (genvar i = 0; i < NL; i++) begin : g_lane
    fir_seq_lane #(.DW(DW)) u_lane (
      .ck(ck), .rst(rst), .load(read), .start(state == START), .run(state == RUN),
      .tmo(tmo), .bypass(byp[i]), .fir_done(fdone[i]), .din(din[i]), .fir_out(fout[i]),
      .res(res[i]), .fir_in(fin[i]), .fir_start(fstart[i]), .done(done[i]),
      .done_nxt(done_nxt[i]), .forced(forced[i])
    );
  end

  assign fir_l_in        = fin[0];
  assign fir_r_in        = fin[1];
  assign fir_l_start     = fstart[0];
  assign fir_r_start     = fstart[1];
  assign writedata_left  = 24'(res[0]) << (24 - DW);
  assign writedata_right = 24'(res[1]) << (24 - DW);
  assign busy            = (state != IDLE) & ~rst;
  assign tsum            = {1'b0, timeout_count} + 9'(forced[0]) + 9'(forced[1]);

  always_comb begin
    nxt   = state;
    read  = 1'b0;
    write = 1'b0;
    case (state)
      IDLE:    if (read_ready) begin read = ~rst; nxt = START; end
      START:   nxt = RUN;
      RUN:     if ((&done_nxt) || tmo) nxt = WAIT_WR;
      WAIT_WR: if (write_ready) begin write = ~rst; nxt = IDLE; end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      state         <= IDLE;
      tcnt          <= '0;
      timeout_count <= '0;
    end else begin
      state <= nxt;
      if (state == START)    tcnt <= '0;
      else if (state == RUN) tcnt <= tcnt + 1'b1;
      if (|forced) timeout_count <= tsum[8] ? 8'hFF : tsum[7:0];
    end
  end
endmodule

// File: tb/tb_fir_stereo_sequencer.sv
// Randomized bench for fir_stereo_sequencer: per-sample expectations (write cycle,
// write data, timeout count) are derived from latencies/bypass flags with plain arithmetic.
module tb_fir_stereo_sequencer;
  localparam int TMO   = 8;
  localparam int NEVER = -1;

  logic        ck = 1'b0;
  logic        rst;
  logic        read_ready;
  logic [23:0] readdata_left, readdata_right;
  logic        read;
  logic        write_ready;
  logic        write;
  logic [23:0] writedata_left, writedata_right;
  logic [15:0] fir_l_in, fir_r_in;
  logic        fir_l_start, fir_r_start;
  logic [15:0] fir_l_out, fir_r_out;
  logic        fir_l_done, fir_r_done;
  logic        bypass_l, bypass_r;
  logic        busy;
  logic [7:0]  timeout_count;

  int vecs = 0;
  int errs = 0;
  int tc_exp = 0;

  fir_stereo_sequencer #(.DW(16), .TIMEOUT(TMO)) dut (
    .ck(ck), .rst(rst), .read_ready(read_ready),
    .readdata_left(readdata_left), .readdata_right(readdata_right), .read(read),
    .write_ready(write_ready), .write(write),
    .writedata_left(writedata_left), .writedata_right(writedata_right),
    .fir_l_in(fir_l_in), .fir_r_in(fir_r_in),
    .fir_l_start(fir_l_start), .fir_r_start(fir_r_start),
    .fir_l_out(fir_l_out), .fir_r_out(fir_r_out),
    .fir_l_done(fir_l_done), .fir_r_done(fir_r_done),
    .bypass_l(bypass_l), .bypass_r(bypass_r),
    .busy(busy), .timeout_count(timeout_count)
  );

  always #5 ck = ~ck;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic quiet();
    read_ready = 1'b0; readdata_left = '0; readdata_right = '0;
    write_ready = 1'b0; fir_l_done = 1'b0; fir_r_done = 1'b0;
    fir_l_out = '0; fir_r_out = '0; bypass_l = 1'b0; bypass_r = 1'b0;
  endtask

  // latency = cycles after the start pulse until the FIR done pulse; NEVER = silent FIR
  task automatic run_sample(input logic [23:0] dl, input logic [23:0] dr,
                            input bit bl, input bit br,
                            input int ll, input int lr, input int gap);
    logic [15:0] sl, sr, el, er;
    int rk_l, rk_r, ready_k, wk, nf;
    sl = dl[23:8];
    sr = dr[23:8];
    rk_l = bl ? 2 : (ll == NEVER ? 2 + TMO : 1 + ll);
    rk_r = br ? 2 : (lr == NEVER ? 2 + TMO : 1 + lr);
    el = bl ? sl : (ll == NEVER ? 16'h0 : sl + 16'd1);
    er = br ? sr : (lr == NEVER ? 16'h0 : sr + 16'd1);
    ready_k = ((rk_l > rk_r) ? rk_l : rk_r) + 1;
    wk = ready_k + gap;
    nf = ((!bl && ll == NEVER) ? 1 : 0) + ((!br && lr == NEVER) ? 1 : 0);
    tc_exp = (tc_exp + nf > 255) ? 255 : tc_exp + nf;

    @(posedge ck); #1;
    quiet();
    read_ready = 1'b1; readdata_left = dl; readdata_right = dr;
    write_ready = 1'($urandom);
    @(negedge ck);
    chk("read_pulse", read, 1);
    chk("idle_busy", busy, 0);
    chk("idle_write", write, 0);

    for (int k = 1; k <= wk; k++) begin
      @(posedge ck); #1;
      read_ready = 1'($urandom);
      readdata_left = 24'($urandom); readdata_right = 24'($urandom);
      bypass_l = (k == 1) ? bl : 1'($urandom);
      bypass_r = (k == 1) ? br : 1'($urandom);
      fir_l_done = 1'b0; fir_l_out = 16'($urandom);
      fir_r_done = 1'b0; fir_r_out = 16'($urandom);
      if (!bl && ll != NEVER && k == 1 + ll) begin fir_l_done = 1'b1; fir_l_out = sl + 16'd1; end
      else if (k == 1 || bl || k > rk_l) fir_l_done = ($urandom % 3 == 0);
      if (!br && lr != NEVER && k == 1 + lr) begin fir_r_done = 1'b1; fir_r_out = sr + 16'd1; end
      else if (k == 1 || br || k > rk_r) fir_r_done = ($urandom % 3 == 0);
      write_ready = (k < ready_k) ? 1'($urandom) : (k >= wk);
      @(negedge ck);
      chk("no_read_busy", read, 0);
      chk("busy", busy, 1);
      if (k == 1) begin
        chk("start_l", fir_l_start, !bl);
        chk("start_r", fir_r_start, !br);
        if (!bl) chk("fir_l_in", fir_l_in, sl);
        if (!br) chk("fir_r_in", fir_r_in, sr);
      end else begin
        chk("start_idle", {fir_l_start, fir_r_start}, 0);
      end
      chk("write", write, k == wk);
      if (k >= ready_k) begin
        chk("wd_left", writedata_left, {el, 8'h00});
        chk("wd_right", writedata_right, {er, 8'h00});
      end
      if (k == wk) chk("timeout_count", timeout_count, tc_exp);
    end
    @(posedge ck); #1;
    quiet();
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rw"}, {read, write}, 0);
    chk({tag, "_start"}, {fir_l_start, fir_r_start}, 0);
    chk({tag, "_fin"}, {fir_l_in, fir_r_in}, 0);
    chk({tag, "_wdl"}, writedata_left, 0);
    chk({tag, "_wdr"}, writedata_right, 0);
    chk({tag, "_tc"}, timeout_count, 0);
  endtask

  task automatic reset_mid();
    @(posedge ck); #1;
    quiet();
    read_ready = 1'b1; readdata_left = 24'h55AA33; readdata_right = 24'h0F0F0F;
    @(negedge ck);
    chk("rm_read", read, 1);
    @(posedge ck); #1; read_ready = 1'b0;   // START
    @(posedge ck); #1;                      // RUN
    @(posedge ck); #1; rst = 1'b1; read_ready = 1'b1;
    @(negedge ck);
    chk("rm_read_in_rst", read, 0);
    chk("rm_busy_in_rst", busy, 0);
    @(posedge ck); #1;
    rst = 1'b0; read_ready = 1'b0;
    fir_l_done = 1'b1; fir_r_done = 1'b1;
    fir_l_out = 16'hDEAD; fir_r_out = 16'hBEEF;
    tc_exp = 0;
    @(negedge ck);
    check_cleared("rm_after");
    @(posedge ck); #1;
    quiet();
    @(negedge ck);
    check_cleared("rm_stale");
  endtask

  initial begin
    quiet();
    rst = 1'b1;
    read_ready = 1'b1;
    repeat (2) @(posedge ck);
    @(negedge ck);
    check_cleared("reset");
    @(posedge ck); #1;
    rst = 1'b0;
    quiet();

    // normal path
    run_sample(24'h123456, 24'hABCDEF, 0, 0, 5, 5, 0);
    // right first, left last; then simultaneous completion
    run_sample(24'h2468AC, 24'h13579B, 0, 0, 8, 2, 0);
    run_sample(24'h00FF00, 24'hFFFF01, 0, 0, 4, 4, 0);
    // bypass one channel, then both
    run_sample(24'h7FFF00, 24'h314159, 1, 0, 0, 3, 0);
    run_sample(24'h808080, 24'h010203, 1, 1, 0, 0, 0);
    // right FIR silent
    run_sample(24'h765432, 24'h222222, 0, 0, 4, NEVER, 0);
    // write backpressure
    run_sample(24'h0A0B0C, 24'hC0B0A0, 0, 0, 3, 6, 50);
    // reset mid-RUN with stale result, then a normal sample
    reset_mid();
    run_sample(24'h111111, 24'h999999, 0, 0, 2, 7, 1);

    for (int i = 0; i < 40; i++) begin
      bit bl, br;
      int ll, lr;
      bl = ($urandom % 4 == 0);
      br = ($urandom % 4 == 0);
      ll = ($urandom % 6 == 0) ? NEVER : 1 + int'($urandom % TMO);
      lr = ($urandom % 6 == 0) ? NEVER : 1 + int'($urandom % TMO);
      run_sample(24'($urandom), 24'($urandom), bl, br, ll, lr, int'($urandom % 4));
    end

    for (int i = 0; i < 300; i++)
      run_sample(24'($urandom), 24'($urandom), 0, 0, NEVER, NEVER, 0);
    @(negedge ck);
    chk("tc_saturated", timeout_count, 255);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
